muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M execute path.
- Accepts one M-extension operation from the EX stage and runs multiplies through a fixed-latency registered multiplier.
- Runs divides and remainders through a radix-2 restoring iteration.
- Drives stall_o to freeze the pipeline front end and EX while busy.
- Returns the result with a one-cycle done_o pulse, which the pipeline uses as ALUResult.

Parameters:
- XLEN, 32, operand/result width.
- MUL_LAT, 2, edges from start acceptance to done_o for MUL*; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  EX holds a valid M-op this cycle.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  XLEN  dividend / multiplicand.
- rs2_i  in  XLEN  divisor / multiplier.
- flush_i  in  1  branch/exception flush; aborts any operation in progress.
- stall_o  out  1  hold IF/ID/EX registers.
- busy_o  out  1  state != IDLE.
- done_o  out  1  single-cycle result-valid pulse.
- result_o  out  XLEN  result; holds until the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, done_o=0, busy_o=0, result_o=0, internal operand registers=0. stall_o=0 while rst=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE transitions:
  - start_i=1, flush_i=0 → operands and op captured at the edge.
  - MUL* → MUL.
  - DIV* with rs2=0 or signed overflow → DONE directly (fast path).
  - Other DIV* → DIV.
- MUL state: counter counts MUL_LAT-1 edges; then DONE.
  - Product is the 2*XLEN product with signedness per op: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL returns the low word; the others return the high word.
- DIV state: exactly XLEN iterations, one per edge, then DONE.
  - Operands are converted to magnitudes at capture for DIV/REM.
  - Per iteration: shift {rem,quo} left 1; if rem ≥ divisor, subtract and set quotient bit.
  - Sign correction is applied on entry to DONE:
    - Quotient negated if the operand signs differ.
    - Remainder takes the dividend's sign.
- Fast-path results:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- DONE state: done_o=1 and result_o valid for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency, counted in edges from the accepting edge to the first cycle done_o=1:
  - MUL*: MUL_LAT.
  - DIV* normal: XLEN+1 (33).
  - DIV* fast path: 1.
- stall_o = (state==IDLE & start_i & ~flush_i) | state==MUL | state==DIV.
  - stall_o is combinational and low in DONE, so EX advances on the edge that ends DONE.
- start_i while busy is ignored. EX is stalled, so the same instruction is still presented; it is not re-accepted until IDLE.
- start_i in the DONE cycle is ignored. The pipeline has advanced, so the next op is accepted in the following IDLE cycle.
- flush_i=1 in MUL or DIV → IDLE at the next edge, no done_o, result_o unchanged.
- flush_i in IDLE has priority over start_i: nothing is accepted.
- flush_i in DONE: done_o still pulses, the state goes to IDLE, and the pipeline discards the result.
- Reset asserted mid-operation: immediate return to the reset values; no done_o follows.
- result_o updates only on entry to DONE.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), MUL_LAT=2 → stall_o high 2 cycles; done_o at edge 2; result_o=0xFFFFFFEB. Repeat with MULH → 0xFFFFFFFF; MULHU → 0x00000006.
- DIV rs1=-20 (0xFFFFFFEC), rs2=3 → done_o exactly 33 edges after acceptance; result 0xFFFFFFFA (-6). REM same operands → 0xFFFFFFFE (-2). DIVU 100/7 → 14; REMU → 2.
- Fast paths, each done_o after 1 edge:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Flush at iteration 10 of DIVU 1000/3 → IDLE next edge; no done_o; result_o keeps its previous value. A new DIVU 9/2 then yields 4 after 33 edges.
- Back-to-back: MUL then DIV, with start_i held through busy and DONE → exactly two done_o pulses. The second op is accepted the cycle after the first DONE; no duplicate acceptance.
- Drop rst low during DIV iteration 5 → all outputs 0 immediately. After release with start_i=0: stall_o=0, busy_o=0, and no done_o for 40 cycles.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer; MUL* via a registered multiplier, DIV*/REM* via radix-2 restoring iteration.
// Latency (accepting edge to done_o): MUL* = MUL_LAT, DIV* = XLEN+1, divide-by-zero / signed overflow = 1.
// Backpressure: stall_o holds IF/ID/EX while an op is accepted or running; start_i is ignored unless IDLE; flush_i aborts.
// Ports: clk/rst (async active-low), start_i/op_i(funct3)/rs1_i/rs2_i/flush_i from EX;
//        stall_o, busy_o, done_o (1-cycle pulse), result_o (held until the next op completes).
module muldiv_seq #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] MUL_END = CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
   localparam logic [CW-1:0] DIV_END = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [1:0]      op_q;          // funct3[1:0]; funct3[2] is implied by the state
   logic [XLEN-1:0] opa_q;         // multiplicand, or dividend magnitude / quotient shift register
   logic [XLEN-1:0] opb_q;         // multiplier, or divisor magnitude
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] result_q;
   logic            neg_quo_q, neg_rem_q;

   // ---------------- acceptance and divide fast path ----------------
   logic            accept, is_mul, div_signed, div_zero, div_ovf, fast;
   logic [XLEN-1:0] fast_res, rs1_mag, rs2_mag;

   assign accept     = (state == S_IDLE) & start_i & ~flush_i;
   assign is_mul     = ~op_i[2];
   assign div_signed = ~op_i[0];
   assign div_zero   = (rs2_i == '0);
   assign div_ovf    = div_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
   assign fast       = div_zero | div_ovf;
   // op_i[1] selects REM/REMU over DIV/DIVU
   assign fast_res   = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
   assign rs1_mag    = (div_signed & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
   assign rs2_mag    = (div_signed & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

   // ---------------- multiplier ----------------
   // Operands come from the ports only when MUL_LAT==1 (result stored on the accepting edge).
   logic              mul_idle, m_a_sgn, m_b_sgn;
   logic [1:0]        m_op;
   logic [XLEN-1:0]   m_a, m_b, mul_res;
   logic [2*XLEN-1:0] m_a_ext, m_b_ext, product;

   assign mul_idle = (state == S_IDLE);
   assign m_op     = mul_idle ? op_i[1:0] : op_q;
   assign m_a      = mul_idle ? rs1_i : opa_q;
   assign m_b      = mul_idle ? rs2_i : opb_q;
   assign m_a_sgn  = (m_op != 2'b11);   // MUL, MULH, MULHSU treat rs1 as signed
   assign m_b_sgn  = ~m_op[1];          // MUL, MULH treat rs2 as signed
   assign m_a_ext  = {{XLEN{m_a_sgn & m_a[XLEN-1]}}, m_a};
   assign m_b_ext  = {{XLEN{m_b_sgn & m_b[XLEN-1]}}, m_b};
   assign product  = m_a_ext * m_b_ext; // low 2*XLEN bits of the extended product are exact
   assign mul_res  = (m_op == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

   // ---------------- restoring divide step ----------------
   logic [XLEN:0]   div_tmp, div_sub;
   logic            div_ge;
   logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, div_res;

   assign div_tmp = {rem_q, opa_q[XLEN-1]};
   assign div_sub = div_tmp - {1'b0, opb_q};
   // rem < divisor keeps the difference within XLEN bits, so its top bit is a pure borrow
   assign div_ge  = ~div_sub[XLEN];
   assign rem_nxt = div_ge ? div_sub[XLEN-1:0] : div_tmp[XLEN-1:0];
   assign quo_nxt = {opa_q[XLEN-2:0], div_ge};
   assign quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
   assign rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
   assign div_res = op_q[1] ? rem_fix : quo_fix;

   logic mul_last, div_last;
   assign mul_last = (cnt == MUL_END);
   assign div_last = (cnt == DIV_END);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_mul)    state_nxt = (MUL_LAT == 1) ? S_DONE : S_MUL;
               else if (fast) state_nxt = S_DONE;
               else           state_nxt = S_DIV;
            end
         end
         S_MUL: begin
            if (flush_i)       state_nxt = S_IDLE;
            else if (mul_last) state_nxt = S_DONE;
         end
         S_DIV: begin
            if (flush_i)       state_nxt = S_IDLE;
            else if (div_last) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         op_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rem_q     <= '0;
         result_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt  <= '0;
                  op_q <= op_i[1:0];
                  if (is_mul) begin
                     opa_q <= rs1_i;
                     opb_q <= rs2_i;
                     if (MUL_LAT == 1) result_q <= mul_res;
                  end else begin
                     opa_q     <= rs1_mag;
                     opb_q     <= rs2_mag;
                     rem_q     <= '0;
                     neg_quo_q <= div_signed & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                     neg_rem_q <= div_signed & rs1_i[XLEN-1];
                     if (fast) result_q <= fast_res;
                  end
               end
            end
            S_MUL: begin
               cnt <= cnt + 1'b1;
               if (!flush_i && mul_last) result_q <= mul_res;
            end
            S_DIV: begin
               cnt   <= cnt + 1'b1;
               opa_q <= quo_nxt;
               rem_q <= rem_nxt;
               if (!flush_i && div_last) result_q <= div_res;
            end
            default: ;
         endcase
      end
   end

   // stall drops in DONE so EX advances on the edge that leaves DONE
   assign stall_o  = rst & (accept | (state == S_MUL) | (state == S_DIV));
   assign busy_o   = (state != S_IDLE);
   assign done_o   = (state == S_DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized + directed bench for muldiv_seq against an arithmetic reference model.
// Latency: checks done_o edge counts per op class; result held after DONE.
// Backpressure: start_i held through busy like a stalled EX stage; flush and reset aborts exercised.
module tb_muldiv_seq;

   localparam int XLEN    = 32;
   localparam int MUL_LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            start_i, flush_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs1_i, rs2_i;
   logic            stall_o, busy_o, done_o;
   logic [XLEN-1:0] result_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] last_res = '0;

   muldiv_seq #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
      .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         default: begin
            if (b == 32'h0) return (op == 3'd6 || op == 3'd7) ? a : 32'hFFFF_FFFF;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return (op == 3'd6) ? 32'h0 : 32'h8000_0000;
            case (op)
               3'd4:    p = sa / sb;
               3'd5:    p = ua / ub;
               3'd6:    p = sa % sb;
               default: p = ua % ub;
            endcase
            return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 3'd4) return MUL_LAT;
      if (b == 32'h0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 one edge after DONE.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit flush_in_done);
      int  lat, el, stl;
      bit  seen;
      el = ref_lat(op, a, b);
      op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1; flush_i = 1'b0;
      #1;
      stl = int'(stall_o);
      lat = 0;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (done_o) seen = 1;
         else stl += int'(stall_o);
      end
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_res"}, result_o, exp);
      chk({tag, "_stall_cycles"}, 32'(stl), 32'(el));
      chk({tag, "_stall_in_done"}, {31'b0, stall_o}, 32'h0);
      start_i = 1'b0;
      flush_i = flush_in_done;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk({tag, "_idle_after"}, {30'b0, busy_o, done_o}, 32'h0);
      chk({tag, "_res_hold"}, result_o, exp);
      last_res = exp;
   endtask

   initial begin
      int n_done, t1, t2, acc;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      rst = 1'b0; start_i = 1'b1; flush_i = 1'b0; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {29'b0, stall_o, busy_o, done_o}, 32'h0);
      chk("reset_res", result_o, 32'h0);
      start_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      // directed results
      run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
      run_op("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      run_op("mulhu",  3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
      run_op("div",    3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0);
      run_op("rem",    3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
      run_op("divu",   3'd5, 32'd100, 32'd7, 32'd14, 0);
      run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2, 1);
      run_op("div_z",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      run_op("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 0);
      run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

      // flush has priority over start in IDLE
      op_i = 3'd5; rs1_i = 32'd50; rs2_i = 32'd5; start_i = 1'b1; flush_i = 1'b1;
      #1;
      chk("idle_flush_stall", {31'b0, stall_o}, 32'h0);
      @(posedge clk); #1;
      chk("idle_flush_busy", {31'b0, busy_o}, 32'h0);
      start_i = 1'b0; flush_i = 1'b0;

      // flush during DIVU iteration 10
      op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("flush_idle", {30'b0, busy_o, done_o}, 32'h0);
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         acc += int'(done_o);
      end
      chk("flush_no_done", 32'(acc), 32'h0);
      chk("flush_res_kept", result_o, last_res);
      run_op("divu_after_flush", 3'd5, 32'd9, 32'd2, 32'd4, 0);

      // back-to-back with start held through busy and DONE
      op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD; start_i = 1'b1;
      n_done = 0; t1 = -1; t2 = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done_o) begin
            n_done++;
            if (n_done == 1) begin
               t1 = i;
               chk("b2b_res1", result_o, 32'hFFFF_FFEB);
               op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
            end else begin
               t2 = i;
               chk("b2b_res2", result_o, 32'd14);
               start_i = 1'b0;
            end
         end
      end
      start_i = 1'b0;
      chk("b2b_done_count", 32'(n_done), 32'd2);
      chk("b2b_first_lat", 32'(t1 + 1), 32'(MUL_LAT));
      chk("b2b_gap", 32'(t2 - t1), 32'(XLEN + 2));
      last_res = 32'd14;

      // reset during DIV iteration 5
      op_i = 3'd4; rs1_i = 32'hFFFF_FFEC; rs2_i = 32'd3; start_i = 1'b1;
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_ctrl", {29'b0, stall_o, busy_o, done_o}, 32'h0);
      chk("rst_mid_res", result_o, 32'h0);
      start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         acc += int'(done_o) + int'(busy_o) + int'(stall_o);
      end
      chk("rst_release_quiet", 32'(acc), 32'h0);

      // randomized ops against the reference model
      for (int k = 0; k < 40; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
            3: rb = $urandom_range(1, 1000);
            default: ;
         endcase
         run_op("rand", rop, ra, rb, ref_res(rop, ra, rb), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
